// File: rtl/div_pkg.sv
// Shared definitions for the shift_sub_div divider: state encoding, constants and
// the sign-magnitude helper used when operands are accepted.
package div_pkg;

    localparam int DIV_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [DIV_WIDTH-1:0] DIV0_QUOT = {DIV_WIDTH{1'b1}};

    // One extra bit keeps |MIN| representable when the operand is signed.
    function automatic logic [DIV_WIDTH:0] abs_ext(input logic [DIV_WIDTH-1:0] value,
                                                   input logic                 is_signed);
        logic [DIV_WIDTH:0] ext;
        ext = {is_signed & value[DIV_WIDTH-1], value};
        if (ext[DIV_WIDTH]) begin
            abs_ext = (~ext) + {{DIV_WIDTH{1'b0}}, 1'b1};
        end else begin
            abs_ext = ext;
        end
    endfunction

endpackage

// File: rtl/shift_sub_div_if.sv
// Start/done handshake and operand/result bus of the shift_sub_div divider.
interface shift_sub_div_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on magnitudes; purely combinational.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH:0]   dvs_in,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quo_out
);
    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH+1:0] trial;

    // Shift the next dividend bit in, trial-subtract, and keep or restore.
    always_comb begin
        rem_sh = {rem_in, quo_in[WIDTH-1]};
        trial  = rem_sh - {1'b0, dvs_in};
        if (trial[WIDTH+1]) begin
            rem_out = rem_sh[WIDTH:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b0};
        end else begin
            rem_out = trial[WIDTH:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/shift_sub_div.sv
// Iterative restoring divider, one quotient bit per clock, RISC-V DIV/DIVU/REM/REMU results.
// Optional macro DIV_EARLY_OUT_EN finishes trivial divides (|a|<|b|, |b|==1) one edge after accept.
module shift_sub_div
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    shift_sub_div_if.slave   bus
);
    localparam int               CW      = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    logic [CW-1:0]    iter_q, iter_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH:0]   dvs_q, dvs_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;
    logic             ov_q, ov_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d;
    logic             overflow_q, overflow_d;

    logic [WIDTH:0]   dd_mag_s;
    logic [WIDTH:0]   dv_mag_s;
    logic [WIDTH:0]   step_rem_s;
    logic [WIDTH-1:0] step_quo_s;
    logic             mag_msb_unused_s;

    assign dd_mag_s         = abs_ext(bus.dividend, bus.is_signed);
    assign dv_mag_s         = abs_ext(bus.divisor, bus.is_signed);
    assign mag_msb_unused_s = dd_mag_s[WIDTH];

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .dvs_in  (dvs_q),
        .rem_out (step_rem_s),
        .quo_out (step_quo_s)
    );

    // Next-state, datapath and result logic of the IDLE/RUN/FIN sequencer.
    always_comb begin
        state_d       = state_q;
        iter_d        = iter_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        dvs_d         = dvs_q;
        neg_quo_d     = neg_quo_q;
        neg_rem_d     = neg_rem_q;
        dz_d          = dz_q;
        ov_d          = ov_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        overflow_d    = overflow_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    busy_d    = 1'b1;
                    dz_d      = 1'b0;
                    ov_d      = 1'b0;
                    neg_quo_d = bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                    neg_rem_d = bus.is_signed & bus.dividend[WIDTH-1];
                    dvs_d     = dv_mag_s;
                    rem_d     = {(WIDTH+1){1'b0}};
                    quo_d     = dd_mag_s[WIDTH-1:0];
                    iter_d    = CW'(WIDTH-1);
                    // Special cases load final magnitudes directly and skip RUN.
                    if (bus.divisor == {WIDTH{1'b0}}) begin
                        quo_d     = DIV0_QUOT;
                        rem_d     = {1'b0, bus.dividend};
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        dz_d      = 1'b1;
                        state_d   = S_FIN;
                    end else if (bus.is_signed && (bus.dividend == MIN_VAL) &&
                                 (bus.divisor == {WIDTH{1'b1}})) begin
                        quo_d     = MIN_VAL;
                        rem_d     = {(WIDTH+1){1'b0}};
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        ov_d      = 1'b1;
                        state_d   = S_FIN;
`ifdef DIV_EARLY_OUT_EN
                    end else if (dd_mag_s < dv_mag_s) begin
                        quo_d     = {WIDTH{1'b0}};
                        rem_d     = {1'b0, bus.dividend};
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = S_FIN;
                    end else if (dv_mag_s == {{WIDTH{1'b0}}, 1'b1}) begin
                        rem_d     = {(WIDTH+1){1'b0}};
                        neg_rem_d = 1'b0;
                        state_d   = S_FIN;
`endif
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                rem_d = step_rem_s;
                quo_d = step_quo_s;
                if (iter_q == {CW{1'b0}}) begin
                    state_d = S_FIN;
                end else begin
                    iter_d = iter_q - CW'(1);
                end
            end
            S_FIN: begin
                done_d        = 1'b1;
                busy_d        = 1'b0;
                state_d       = S_IDLE;
                quotient_d    = neg_quo_q ? (~quo_q + WIDTH'(1'b1)) : quo_q;
                remainder_d   = neg_rem_q ? (~rem_q[WIDTH-1:0] + WIDTH'(1'b1)) : rem_q[WIDTH-1:0];
                div_by_zero_d = dz_q;
                overflow_d    = ov_q;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs; reset drops any divide in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            iter_q        <= {CW{1'b0}};
            rem_q         <= {(WIDTH+1){1'b0}};
            quo_q         <= {WIDTH{1'b0}};
            dvs_q         <= {(WIDTH+1){1'b0}};
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            dz_q          <= 1'b0;
            ov_q          <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= {WIDTH{1'b0}};
            remainder_q   <= {WIDTH{1'b0}};
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            iter_q        <= iter_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            dvs_q         <= dvs_d;
            neg_quo_q     <= neg_quo_d;
            neg_rem_q     <= neg_rem_d;
            dz_q          <= dz_d;
            ov_q          <= ov_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
            overflow_q    <= overflow_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = div_by_zero_q;
    assign bus.overflow    = overflow_q;
endmodule
